// File: rtl/ram_access_controller_pkg.sv
// Shared definitions for the RAM access blocks: controller state encoding and
// default geometry. Optional burst support is selected by RAM_CTRL_BURST_EN.
package ram_access_controller_pkg;

    // Default geometry of the downstream RAM addresser.
    localparam int DEFAULT_ADDR_W       = 4;
    localparam int DEFAULT_DATA_W       = 4;
    localparam int DEFAULT_READ_LATENCY = 2;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/ram_access_controller.sv
// ram_access_controller: accepts read/write commands, drives a registered
// address/data/mode interface to a RAM addresser with fixed read latency, and
// returns read data over a valid/ready response channel.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. rsp_valid/rsp_data/rsp_addr stay
// stable until that edge. Commands offered while busy are not accepted.
//
// Optional feature: define RAM_CTRL_BURST_EN to add the cmd_count port; a
// command then performs cmd_count+1 beats at incrementing (wrapping)
// addresses. Without it every command is a single beat.
module ram_access_controller
    import ram_access_controller_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
`ifdef RAM_CTRL_BURST_EN
    input  logic [ADDR_W-1:0] cmd_count,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_read_mode,
    output logic              ram_write_mode,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output ctrl_state_t       fsm_state
);

    // Wait counter must hold READ_LATENCY; keep at least one bit.
    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY);

    ctrl_state_t      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_beat;

`ifdef RAM_CTRL_BURST_EN
    // Beats still to issue after the current one.
    logic [ADDR_W-1:0] beats_left;
    assign last_beat = (beats_left == '0);
`else
    assign last_beat = 1'b1;
`endif

    // Status decoded straight from the state register.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // Controller FSM with registered RAM drive and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_addr       <= '0;
            ram_address    <= '0;
            ram_data       <= '0;
            ram_read_mode  <= 1'b1;
            ram_write_mode <= 1'b0;
`ifdef RAM_CTRL_BURST_EN
            beats_left     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        ram_address <= cmd_addr;
`ifdef RAM_CTRL_BURST_EN
                        beats_left  <= cmd_count;
`endif
                        if (cmd_write) begin
                            ram_data       <= cmd_data;
                            ram_write_mode <= 1'b1;
                            ram_read_mode  <= 1'b0;
                            state          <= WRITE;
                        end else begin
                            ram_write_mode <= 1'b0;
                            ram_read_mode  <= 1'b1;
                            wait_cnt       <= LAT_LOAD;
                            state          <= RD_WAIT;
                        end
                    end
                end

                WRITE: begin
                    // One beat written per cycle; same data fills every beat.
                    if (last_beat) begin
                        ram_write_mode <= 1'b0;
                        ram_read_mode  <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        ram_address <= ram_address + ADDR_W'(1);
`ifdef RAM_CTRL_BURST_EN
                        beats_left  <= beats_left - ADDR_W'(1);
`endif
                    end
                end

                RD_WAIT: begin
                    // ram_data_out is valid once the counter has run down.
                    if (wait_cnt == '0) begin
                        rsp_data  <= ram_data_out;
                        rsp_addr  <= ram_address;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            ram_address <= ram_address + ADDR_W'(1);
`ifdef RAM_CTRL_BURST_EN
                            beats_left  <= beats_left - ADDR_W'(1);
`endif
                            wait_cnt    <= LAT_LOAD;
                            state       <= RD_WAIT;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_controller.sv
// Testbench for ram_access_controller: table-driven single-beat commands,
// hand-written stall, reset-abort and (with RAM_CTRL_BURST_EN) burst sequences.
module tb_ram_access_controller;
    import ram_access_controller_pkg::*;

    localparam int AW  = 4;
    localparam int DW  = 4;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
`ifdef RAM_CTRL_BURST_EN
    logic [AW-1:0] cmd_count;
`endif
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_read_mode;
    logic          ram_write_mode;
    logic [DW-1:0] ram_data_out;
    logic          busy;
    ctrl_state_t   fsm_state;

    ram_access_controller #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
`ifdef RAM_CTRL_BURST_EN
        .cmd_count      (cmd_count),
`endif
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_addr       (rsp_addr),
        .ram_address    (ram_address),
        .ram_data       (ram_data),
        .ram_read_mode  (ram_read_mode),
        .ram_write_mode (ram_write_mode),
        .ram_data_out   (ram_data_out),
        .busy           (busy),
        .fsm_state      (fsm_state)
    );

    // ---------------- RAM addresser model: 2-cycle read latency ----------------
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_d1;
    logic [DW-1:0] rd_d2;

    always @(posedge clock) begin
        if (ram_write_mode) mem[ram_address] <= ram_data;
        rd_d1 <= mem[ram_address];
        rd_d2 <= rd_d1;
    end
    assign ram_data_out = rd_d2;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Read and write modes must always be complementary.
    always @(negedge clock) begin
        if (mon_en) check("mode_excl", 32'(ram_read_mode ^ ram_write_mode), 32'd1);
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
        check({tag, "_ram_address"}, 32'(ram_address), 32'd0);
        check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
        check({tag, "_read_mode"}, 32'(ram_read_mode), 32'd1);
        check({tag, "_write_mode"}, 32'(ram_write_mode), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        check("wr_write_mode", 32'(ram_write_mode), 32'd1);
        check("wr_read_mode", 32'(ram_read_mode), 32'd0);
        check("wr_address", 32'(ram_address), 32'(a));
        check("wr_data", 32'(ram_data), 32'(d));
        check("wr_state", 32'(fsm_state), 32'(WRITE));
        check("wr_busy_ready", 32'({busy, cmd_ready}), 32'b10);
        step();
        check("wr_done_modes", 32'({ram_read_mode, ram_write_mode}), 32'b10);
        check("wr_done_state", 32'(fsm_state), 32'(IDLE));
        check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
        int edges;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        step();
        cmd_valid = 1'b0;
        check("rd_address", 32'(ram_address), 32'(a));
        check("rd_state", 32'(fsm_state), 32'(RD_WAIT));
        check("rd_cmd_ready", 32'(cmd_ready), 32'd0);
        edges = 0;
        while (edges < 20) begin
            step();
            edges++;
            if (rsp_valid) break;
        end
        check("rd_latency", 32'(edges), 32'(LAT + 1));
        check("rd_data", 32'(rsp_data), 32'(exp_d));
        check("rd_addr", 32'(rsp_addr), 32'(a));
        step();
        check("rd_rsp_cleared", 32'(rsp_valid), 32'd0);
        check("rd_done_state", 32'(fsm_state), 32'(IDLE));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs [10];

    // ---------------- main test ----------------
    initial begin
        int n;

        vecs[0] = '{1'b1, 4'd3,  4'hA};
        vecs[1] = '{1'b0, 4'd3,  4'hA};
        vecs[2] = '{1'b1, 4'd0,  4'h5};
        vecs[3] = '{1'b1, 4'd15, 4'hF};
        vecs[4] = '{1'b0, 4'd15, 4'hF};
        vecs[5] = '{1'b0, 4'd0,  4'h5};
        vecs[6] = '{1'b1, 4'd7,  4'h0};
        vecs[7] = '{1'b0, 4'd7,  4'h0};
        vecs[8] = '{1'b1, 4'd3,  4'h6};
        vecs[9] = '{1'b0, 4'd3,  4'h6};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
`ifdef RAM_CTRL_BURST_EN
        cmd_count = '0;
`endif
        repeat (2) step();
        check_reset_values("rst");
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        // Table-driven single-beat commands.
        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data);
        end

        // Response back-pressure: held response stays stable, new command ignored.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd3;
        step();
        cmd_write = 1'b1;
        cmd_addr  = 4'd3;
        cmd_data  = 4'h1;
        n = 0;
        while (n < 20 && !rsp_valid) begin
            step();
            n++;
        end
        check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            step();
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_data", 32'(rsp_data), 32'h6);
            check("stall_rsp_addr", 32'(rsp_addr), 32'd3);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_no_write", 32'(ram_write_mode), 32'd0);
        end
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("stall_release", 32'(rsp_valid), 32'd0);
        check("stall_idle", 32'(fsm_state), 32'(IDLE));
        do_read(4'd3, 4'h6);

        // Reset during RD_WAIT aborts the read; no response appears afterwards.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd7;
        step();
        cmd_valid = 1'b0;
        step();
        check("abort_in_rd_wait", 32'(fsm_state), 32'(RD_WAIT));
        reset = 1'b1;
        step();
        check_reset_values("abort");
        reset = 1'b0;
        repeat (8) begin
            step();
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

`ifdef RAM_CTRL_BURST_EN
        // Burst read across the top of the address space.
        do_write(4'd14, 4'h1);
        do_write(4'd15, 4'h2);
        do_write(4'd0,  4'h3);
        do_write(4'd1,  4'h4);
        exp_q.push_back({4'd14, 4'h1});
        exp_q.push_back({4'd15, 4'h2});
        exp_q.push_back({4'd0,  4'h3});
        exp_q.push_back({4'd1,  4'h4});
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd14;
        cmd_count = 4'd3;
        step();
        cmd_valid = 1'b0;
        cmd_count = '0;
        n = 0;
        while (n < 60 && exp_q.size() != 0) begin
            step();
            n++;
            if (rsp_valid) begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("burst_rsp_addr", 32'(rsp_addr), 32'(e[AW+DW-1:DW]));
                check("burst_rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
            end
        end
        check("burst_all_rsp", 32'(exp_q.size()), 32'd0);
        step();
        check("burst_idle", 32'(fsm_state), 32'(IDLE));

        // Burst write of two beats wrapping 15 -> 0.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd15;
        cmd_data  = 4'h9;
        cmd_count = 4'd1;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_count = '0;
        check("bwr_beat0", 32'({ram_write_mode, ram_address, ram_data}), 32'({1'b1, 4'd15, 4'h9}));
        step();
        check("bwr_beat1", 32'({ram_write_mode, ram_address, ram_data}), 32'({1'b1, 4'd0, 4'h9}));
        step();
        check("bwr_done", 32'({ram_write_mode, busy}), 32'b00);
`endif

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_controller.md
RAM_ACCESS_CONTROLLER -- requirements
Module: ram_access_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, RAM data width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from a registered read address to valid ram_data_out.
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake, transfer when both high on a rising edge.
REQ-007 SHALL have ports cmd_write in 1 (1=write, 0=read), cmd_addr in ADDR_W, cmd_data in DATA_W: command payload.
REQ-008 SHALL have port cmd_count in ADDR_W: burst beats minus one, present only with RAM_CTRL_BURST_EN.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DATA_W, rsp_addr out ADDR_W: read-response handshake.
REQ-010 SHALL have ports ram_address out ADDR_W, ram_data out DATA_W, ram_read_mode out 1, ram_write_mode out 1: registered drive to the downstream RAM addresser.
REQ-011 SHALL have port ram_data_out in DATA_W: read data returned by the RAM addresser.
REQ-012 SHALL have port busy out 1: high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, RD_WAIT, RESP.
REQ-014 IDLE: cmd_ready=1, ram_read_mode=1, ram_write_mode=0; all other states cmd_ready=0.
REQ-015 On accept with cmd_write=1: same edge registers ram_address=cmd_addr, ram_data=cmd_data, ram_write_mode=1, ram_read_mode=0, state WRITE.
REQ-016 WRITE: one cycle per beat; on last beat edge returns ram_write_mode=0, ram_read_mode=1, state IDLE; writes produce no response.
REQ-017 On accept with cmd_write=0: registers ram_address=cmd_addr, ram_read_mode=1, loads wait counter with READ_LATENCY, state RD_WAIT.
REQ-018 RD_WAIT: counter decrements each cycle; at zero, captures ram_data_out into rsp_data, ram_address into rsp_addr, sets rsp_valid, state RESP; rsp_valid rises READ_LATENCY+1 edges after acceptance.
REQ-019 RESP: rsp_valid, rsp_data, rsp_addr held stable until rsp_ready; on handshake edge rsp_valid=0 and next beat issued (RD_WAIT) or state IDLE.
REQ-020 ram_read_mode and ram_write_mode SHALL never be 1/1 or 0/0 simultaneously.
REQ-021 Commands presented while busy SHALL be ignored (cmd_ready low), never queued.
REQ-022 Address increment for beats SHALL be modulo 2^ADDR_W (max address wraps to 0).

Reset
REQ-023 Reset SHALL force state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_addr=0, ram_address=0, ram_data=0, ram_read_mode=1, ram_write_mode=0, busy=0, counters 0.
REQ-024 Reset mid-operation SHALL abort the transfer; remaining beats and pending response are discarded.

Configuration
REQ-025 With RAM_CTRL_BURST_EN defined: command performs cmd_count+1 beats at incrementing addresses; write bursts fill cmd_data into every beat, one cycle per beat; read bursts return one response per beat in address order.
REQ-026 Without RAM_CTRL_BURST_EN: cmd_count port absent, every command is exactly one beat.

Structure
REQ-027 FSM state encodings and default widths SHALL live in the shared ram package/header used by the RAM blocks.
REQ-028 No sub-module; the latency counter is inline.

Verification
REQ-029 Reset, then write addr 3 data 0xA -> one cycle ram_write_mode=1, ram_address=3, ram_data=0xA, then IDLE, no rsp_valid.
REQ-030 Read addr 3, model returns 0xA after 2 cycles, rsp_ready=1 -> rsp_valid high exactly 3 edges after accept, rsp_data=0xA, rsp_addr=3.
REQ-031 Read with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data stable, cmd_ready=0 and a second cmd_valid ignored throughout.
REQ-032 RAM_CTRL_BURST_EN: read burst addr 14 count 3 -> responses at addresses 14,15,0,1 in order.
REQ-033 Assert reset during RD_WAIT -> next edge all outputs at reset values, no response ever emitted.
